stream_sorter: RTL and testbench

Sequential, handshaked sorter that accepts a block of up to N unsigned DW-bit words one per cycle and emits them one per cycle in ascending order. It is the streaming-side counterpart of the combinational `parallel_sorter`, for paths where data arrives serially and a full N-wide bus is not available. Internally it is an insertion array of N cells, with one comparator per cell. Load and drain phases alternate, and blocks never overlap.

---
 rtl/sorter_pkg.sv | 28 ++
 rtl/sort_cell.sv | 49 ++++
 rtl/stream_sorter.sv | 135 +++++++++++++
 tb/tb_stream_sorter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared types and helpers for the streaming insertion sorter.
// Build option: STREAM_SORTER_DESCEND_EN selects descending order.
package sorter_pkg;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

`ifdef STREAM_SORTER_DESCEND_EN
  localparam bit SORT_DESCEND = 1'b1;
`else
  localparam bit SORT_DESCEND = 1'b0;
`endif

endpackage

// File: rtl/sort_cell.sv
// One insertion-array cell: value, occupied flag, compare-and-shift.
// Ports: load/drain strobes, din, lower/upper neighbour state, val/occ/gt out.
module sort_cell
  import sorter_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] lo_val,
  input  logic          lo_occ,
  input  logic          lo_gt,
  input  logic [DW-1:0] hi_val,
  input  logic          hi_occ,
  output logic [DW-1:0] val,
  output logic          occ,
  output logic          gt
);

  logic cmp;

  // Strict compare keeps equal words in arrival order.
  assign cmp = SORT_DESCEND ? (val < din) : (val > din);
  assign gt  = occ && cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
      occ <= 1'b0;
    end else if (load) begin
      if (lo_gt) begin
        // lower cell moves up into this slot
        val <= lo_val;
        occ <= 1'b1;
      end else if (lo_occ && (gt || !occ)) begin
        // lowest freed slot, or first empty slot
        val <= din;
        occ <= 1'b1;
      end
    end else if (drain) begin
      val <= hi_val;
      occ <= hi_occ;
    end
  end

endmodule

// File: rtl/stream_sorter.sv
// Streaming insertion sorter: loads up to N words, drains them in order.
// Ports: in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_data/out_last.
module stream_sorter
  import sorter_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam int CW = clog2(N + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          in_ready_d;
  logic          out_valid_d;
  logic          out_last_d;
  logic          in_fire;
  logic          out_fire;

  logic [DW-1:0] val_a    [N];
  logic          occ_a    [N];
  logic          gt_a     [N];
  logic [DW-1:0] lo_val_a [N];
  logic          lo_occ_a [N];
  logic          lo_gt_a  [N];
  logic [DW-1:0] hi_val_a [N];
  logic          hi_occ_a [N];

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  for (genvar k = 0; k < N; k++) begin : g_cell
    if (k == 0) begin : g_lo0
      assign lo_val_a[k] = '0;
      assign lo_occ_a[k] = 1'b1;
      assign lo_gt_a[k]  = 1'b0;
    end else begin : g_lo
      assign lo_val_a[k] = val_a[k-1];
      assign lo_occ_a[k] = occ_a[k-1];
      assign lo_gt_a[k]  = gt_a[k-1];
    end
    if (k == N - 1) begin : g_hitop
      assign hi_val_a[k] = '0;
      assign hi_occ_a[k] = 1'b0;
    end else begin : g_hi
      assign hi_val_a[k] = val_a[k+1];
      assign hi_occ_a[k] = occ_a[k+1];
    end

    sort_cell #(
      .DW(DW)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (in_fire),
      .drain (out_fire),
      .din   (in_data),
      .lo_val(lo_val_a[k]),
      .lo_occ(lo_occ_a[k]),
      .lo_gt (lo_gt_a[k]),
      .hi_val(hi_val_a[k]),
      .hi_occ(hi_occ_a[k]),
      .val   (val_a[k]),
      .occ   (occ_a[k]),
      .gt    (gt_a[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == ST_LOAD): begin
        if (in_fire) begin
          cnt_d = cnt_q + CNT_ONE;
          if (in_last || (cnt_q == CNT_TOP)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      (state_q == ST_DRAIN): begin
        if (out_fire) begin
          cnt_d = cnt_q - CNT_ONE;
          if (out_last_q) begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    in_ready_d  = (state_d == ST_LOAD);
    out_valid_d = (state_d == ST_DRAIN);
    out_last_d  = out_valid_d && (cnt_d == CNT_ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = val_a[0];

endmodule

// File: tb/tb_stream_sorter.sv
// Scoreboard bench for stream_sorter: directed cases plus random blocks.
// Reference model: stable sort of each accepted block with arrival tags.
module tb_stream_sorter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  stream_sorter #(.N(N), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int val;
    int tag;
  } item_t;

  int    vectors = 0;
  int    miscompares = 0;
  int    exp_q[$];
  bit    exp_last_q[$];
  item_t blk[$];
  int    tag_ctr = 0;
  int    accepted = 0;
  bit    hold_pending = 0;
  int    held_data;
  int    held_last;
  bit    done = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic bit goes_before(input int a, input int b);
`ifdef STREAM_SORTER_DESCEND_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

  // Stable sort: a word lands after every earlier word it does not precede.
  task automatic close_block();
    item_t srt[$];
    int    pos;
    foreach (blk[i]) begin
      pos = srt.size();
      for (int j = 0; j < srt.size(); j++) begin
        if (goes_before(blk[i].val, srt[j].val)) begin
          pos = j;
          break;
        end
      end
      srt.insert(pos, blk[i]);
    end
    foreach (srt[i]) begin
      exp_q.push_back(srt[i].val);
      exp_last_q.push_back(i == srt.size() - 1);
    end
    blk.delete();
  endtask

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) accepted++;
  end

  // Monitor: compare every output handshake, check stability under stall.
  always @(negedge clk) begin
    int d;
    bit l;
    if (rst_n) begin
      if (hold_pending) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), held_data);
        check("stall_last", int'(out_last), held_last);
      end
      hold_pending = out_valid && !out_ready;
      held_data = int'(out_data);
      held_last = int'(out_last);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'(out_data), -1);
        end else begin
          d = exp_q.pop_front();
          l = exp_last_q.pop_front();
          check("out_data", int'(out_data), d);
          check("out_last", int'(out_last), int'(l));
        end
      end
    end else begin
      hold_pending = 0;
    end
  end

  task automatic push_word(input int d, input bit last);
    int n;
    in_valid = 1'b1;
    in_data  = DW'(d);
    in_last  = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    @(posedge clk);
    blk.push_back('{d, tag_ctr});
    tag_ctr++;
    if (last || blk.size() == N) close_block();
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) return;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_last_fire();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) return;
    end
    check("last_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int d;
    bit l;
    int acc0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_data", int'(out_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_before_edge", int'(in_ready), 0);
    @(negedge clk);
    check("in_ready_after_edge", int'(in_ready), 1);

    // 7,3,9,1: full block, latency check
    @(posedge clk);
    #1;
    push_word(7, 0);
    push_word(3, 0);
    push_word(9, 0);
    check("valid_low_in_load", int'(out_valid), 0);
    push_word(1, 0);
    @(negedge clk);
    check("latency_valid", int'(out_valid), 1);
    check("latency_in_ready", int'(in_ready), 0);
    wait_drain();

    // short block 5,2
    @(posedge clk);
    #1;
    push_word(5, 0);
    push_word(2, 1);
    wait_last_fire();
    @(negedge clk);
    check("short_in_ready_back", int'(in_ready), 1);
    check("short_valid_drop", int'(out_valid), 0);
    wait_drain();

    // ties
    @(posedge clk);
    #1;
    push_word(4, 0);
    push_word(4, 0);
    push_word(0, 0);
    push_word(255, 0);
    wait_drain();

    // single-word block
    @(posedge clk);
    #1;
    push_word(77, 1);
    wait_drain();

    // backpressure with in_valid held during drain
    @(posedge clk);
    #1;
    push_word(10, 0);
    push_word(30, 0);
    push_word(20, 0);
    out_ready = 1'b0;
    push_word(40, 0);
    out_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd99;
    in_last  = 1'b1;
    acc0 = accepted;
    repeat (3) begin
      @(negedge clk);
      check("drain_in_ready", int'(in_ready), 0);
    end
    check("drain_no_accept", accepted, acc0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // reset after two words
    @(posedge clk);
    #1;
    push_word(11, 0);
    push_word(12, 0);
    rst_n = 1'b0;
    #1;
    blk.delete();
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_last", int'(out_last), 0);
    check("midrst_out_data", int'(out_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_word(8, 0);
    push_word(6, 0);
    push_word(4, 0);
    push_word(2, 0);
    wait_drain();

    // random blocks with random backpressure
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          len = $urandom_range(1, N);
          for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) begin
              in_last = 1'($urandom);
              @(posedge clk);
              #1;
            end
            d = ($urandom_range(0, 1) != 0) ?
                $urandom_range(0, 7) : $urandom_range(0, 255);
            if (i == len - 1) l = (len < N) ? 1'b1 : 1'($urandom);
            else l = 1'b0;
            push_word(d, l);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
